// File: rtl/usb_in_sched_pkg.sv
// Shared types and default timing constants for the IN-endpoint scheduler.
package usb_in_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } sched_state_t;

  // 1 ms ack watchdog and 1 s host-presence window at 48 MHz
  localparam int DEFAULT_TIMEOUT_CYC  = 48000;
  localparam int DEFAULT_PRESENCE_CYC = 48000000;

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after `last`, wrapping.
module usb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          valid
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // Offset N wraps back to `last` itself, so a lone requester can win again
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/usb_in_ep_sched.sv
// Round-robin IN-endpoint slot scheduler with ack watchdog and SOF presence gating.
// Optional per-frame packet budget enabled by defining USB_IN_SCHED_BUDGET_EN.
module usb_in_ep_sched
  import usb_in_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int BUDGET       = 4,
  parameter int TIMEOUT_CYC  = DEFAULT_TIMEOUT_CYC,
  parameter int PRESENCE_CYC = DEFAULT_PRESENCE_CYC
) (
  input  logic                       clk_48mhz,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_in_ep_req,
  output logic [NUM_REQ-1:0]         req_in_ep_grant,
  output logic                       pe_in_ep_req,
  input  logic                       pe_in_ep_grant,
  input  logic                       pe_in_ep_acked,
  input  logic                       sof_valid,
  output logic                       host_present,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       timeout_err
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW  = $clog2(PRESENCE_CYC + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BUDGET < 1 || TIMEOUT_CYC < 1 || PRESENCE_CYC < 1) begin : g_param_check
    $error("usb_in_ep_sched: parameter out of range");
  end

  sched_state_t   state_reg, state_next;
  logic [IW-1:0]  owner_reg, owner_next;
  logic [IW-1:0]  last_reg, last_next;
  logic [WDW-1:0] wd_reg, wd_next;
  logic           timeout_reg, timeout_next;
  logic [PW-1:0]  pres_cnt_reg;
  logic           host_present_reg;
  logic           count_ack;

  logic [NUM_REQ-1:0] eligible;
  logic [IW-1:0]      pick_winner;
  logic               pick_valid;

`ifdef USB_IN_SCHED_BUDGET_EN
  localparam int BW = $clog2(BUDGET + 1);

  // Never exceeds BUDGET: a requester at its limit cannot be granted again
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_budget
    logic [BW-1:0] pkt_cnt_reg;

    always_ff @(posedge clk_48mhz) begin
      if (reset || sof_valid) begin
        pkt_cnt_reg <= '0;
      end else if (count_ack && owner_reg == IW'(gi)) begin
        pkt_cnt_reg <= pkt_cnt_reg + BW'(1);
      end
    end

    assign eligible[gi] = req_in_ep_req[gi] && (pkt_cnt_reg != BW'(BUDGET));
  end
`else
  assign eligible = req_in_ep_req;
`endif

  usb_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .last     (last_reg),
    .winner   (pick_winner),
    .valid    (pick_valid)
  );

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    last_next    = last_reg;
    wd_next      = wd_reg;
    timeout_next = 1'b0;
    count_ack    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (host_present_reg && pick_valid) begin
          state_next = ST_OWN;
          owner_next = pick_winner;
          wd_next    = '0;
        end
      end
      ST_OWN: begin
        // Ack takes priority over a simultaneous request drop
        if (pe_in_ep_acked) begin
          state_next = ST_IDLE;
          last_next  = owner_reg;
          count_ack  = 1'b1;
        end else if (!req_in_ep_req[owner_reg]) begin
          state_next = ST_IDLE;
          last_next  = owner_reg;
        end else if (wd_reg == WDW'(TIMEOUT_CYC - 1)) begin
          state_next   = ST_IDLE;
          last_next    = owner_reg;
          timeout_next = 1'b1;
        end else begin
          wd_next = wd_reg + WDW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= '0;
      last_reg    <= IW'(NUM_REQ - 1);
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      wd_reg      <= wd_next;
      timeout_reg <= timeout_next;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      pres_cnt_reg     <= '0;
      host_present_reg <= 1'b0;
    end else if (sof_valid) begin
      pres_cnt_reg     <= '0;
      host_present_reg <= 1'b1;
    end else begin
      if (pres_cnt_reg != PW'(PRESENCE_CYC)) begin
        pres_cnt_reg <= pres_cnt_reg + PW'(1);
      end
      if (pres_cnt_reg == PW'(PRESENCE_CYC)) begin
        host_present_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign req_in_ep_grant[gi] = (state_reg == ST_OWN) && (owner_reg == IW'(gi)) && pe_in_ep_grant;
  end

  assign pe_in_ep_req = (state_reg == ST_OWN);
  assign host_present = host_present_reg;
  assign owner        = owner_reg;
  assign timeout_err  = timeout_reg;

endmodule

// File: tb/tb_usb_in_ep_sched.sv
// Cycle-vector bench for usb_in_ep_sched with scaled timeout/presence windows.
module tb_usb_in_ep_sched;

  localparam int NREQ = 2;
  localparam int TO   = 500;
  localparam int PRES = 1000;

  typedef struct packed {
    logic       pe;
    logic [1:0] grant;
    logic       own;
    logic       to;
    logic       hp;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] req;
    logic       pg;
    logic       ack;
    logic       sof;
    exp_t       e;
  } vec_t;

  typedef struct {
    exp_t  e;
    string tag;
  } sb_t;

  logic       clk_48mhz = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_in_ep_req = '0;
  logic [1:0] req_in_ep_grant;
  logic       pe_in_ep_req;
  logic       pe_in_ep_grant = 1'b0;
  logic       pe_in_ep_acked = 1'b0;
  logic       sof_valid = 1'b0;
  logic       host_present;
  logic       owner;
  logic       timeout_err;

  int  checks = 0;
  int  failures = 0;
  sb_t sb_q[$];
  sb_t mon_ent;
  exp_t act;
  vec_t tbl[26];

  always #5 clk_48mhz = ~clk_48mhz;

  usb_in_ep_sched #(
    .NUM_REQ      (NREQ),
    .BUDGET       (4),
    .TIMEOUT_CYC  (TO),
    .PRESENCE_CYC (PRES)
  ) dut (
    .clk_48mhz       (clk_48mhz),
    .reset           (reset),
    .req_in_ep_req   (req_in_ep_req),
    .req_in_ep_grant (req_in_ep_grant),
    .pe_in_ep_req    (pe_in_ep_req),
    .pe_in_ep_grant  (pe_in_ep_grant),
    .pe_in_ep_acked  (pe_in_ep_acked),
    .sof_valid       (sof_valid),
    .host_present    (host_present),
    .owner           (owner),
    .timeout_err     (timeout_err)
  );

  function automatic exp_t ex(input logic pe, input logic [1:0] gr, input logic own,
                              input logic to, input logic hp);
    exp_t e;
    e.pe = pe; e.grant = gr; e.own = own; e.to = to; e.hp = hp;
    return e;
  endfunction

  function automatic vec_t vv(input logic r, input logic [1:0] rq, input logic g, input logic a,
                              input logic s, input exp_t e);
    vec_t v;
    v.rst = r; v.req = rq; v.pg = g; v.ack = a; v.sof = s; v.e = e;
    return v;
  endfunction

  // One cycle: drive after the rising edge, queue the outputs expected before the next one
  task automatic step(input logic r, input logic [1:0] rq, input logic g, input logic a,
                      input logic s, input exp_t e, input string tag, input bit chk);
    sb_t ent;
    @(posedge clk_48mhz);
    #1;
    reset = r; req_in_ep_req = rq; pe_in_ep_grant = g; pe_in_ep_acked = a; sof_valid = s;
    if (chk) begin
      ent.e = e;
      ent.tag = tag;
      sb_q.push_back(ent);
    end
  endtask

  always @(negedge clk_48mhz) begin
    if (sb_q.size() != 0) begin
      mon_ent = sb_q.pop_front();
      act = ex(pe_in_ep_req, req_in_ep_grant, owner, timeout_err, host_present);
      checks++;
      if (act !== mon_ent.e) begin
        failures++;
        $display("FAIL %s: got pe=%b grant=%b owner=%b to=%b hp=%b, want pe=%b grant=%b owner=%b to=%b hp=%b",
                 mon_ent.tag, act.pe, act.grant, act.own, act.to, act.hp,
                 mon_ent.e.pe, mon_ent.e.grant, mon_ent.e.own, mon_ent.e.to, mon_ent.e.hp);
      end else begin
        $display("ok   %s: pe=%b grant=%b owner=%b to=%b hp=%b",
                 mon_ent.tag, act.pe, act.grant, act.own, act.to, act.hp);
      end
    end
  end

  initial begin
    // reset, single requester with ack at relative cycle 5
    tbl[0]  = vv(1, 2'b00, 0, 0, 0, ex(0, 2'b00, 0, 0, 0));
    tbl[1]  = vv(1, 2'b01, 0, 0, 0, ex(0, 2'b00, 0, 0, 0));
    tbl[2]  = vv(0, 2'b00, 0, 0, 1, ex(0, 2'b00, 0, 0, 0));
    tbl[3]  = vv(0, 2'b01, 0, 0, 0, ex(0, 2'b00, 0, 0, 1));
    tbl[4]  = vv(0, 2'b01, 1, 0, 0, ex(1, 2'b01, 0, 0, 1));
    tbl[5]  = vv(0, 2'b01, 0, 0, 0, ex(1, 2'b00, 0, 0, 1));
    tbl[6]  = vv(0, 2'b01, 1, 0, 0, ex(1, 2'b01, 0, 0, 1));
    tbl[7]  = vv(0, 2'b01, 1, 0, 0, ex(1, 2'b01, 0, 0, 1));
    tbl[8]  = vv(0, 2'b01, 1, 1, 0, ex(1, 2'b01, 0, 0, 1));
    tbl[9]  = vv(0, 2'b00, 0, 0, 0, ex(0, 2'b00, 0, 0, 1));
    // re-reset, both requesting: owners 0,1,0,1
    tbl[10] = vv(1, 2'b00, 0, 0, 0, ex(0, 2'b00, 0, 0, 1));
    tbl[11] = vv(0, 2'b00, 0, 0, 1, ex(0, 2'b00, 0, 0, 0));
    tbl[12] = vv(0, 2'b11, 0, 0, 0, ex(0, 2'b00, 0, 0, 1));
    tbl[13] = vv(0, 2'b11, 1, 1, 0, ex(1, 2'b01, 0, 0, 1));
    tbl[14] = vv(0, 2'b11, 1, 0, 0, ex(0, 2'b00, 0, 0, 1));
    tbl[15] = vv(0, 2'b11, 1, 1, 0, ex(1, 2'b10, 1, 0, 1));
    tbl[16] = vv(0, 2'b11, 1, 0, 0, ex(0, 2'b00, 1, 0, 1));
    tbl[17] = vv(0, 2'b11, 1, 1, 0, ex(1, 2'b01, 0, 0, 1));
    tbl[18] = vv(0, 2'b11, 1, 0, 0, ex(0, 2'b00, 0, 0, 1));
    tbl[19] = vv(0, 2'b11, 1, 1, 0, ex(1, 2'b10, 1, 0, 1));
    tbl[20] = vv(0, 2'b00, 0, 0, 0, ex(0, 2'b00, 1, 0, 1));
    // request drop without ack still advances the round-robin pointer
    tbl[21] = vv(0, 2'b01, 0, 0, 0, ex(0, 2'b00, 1, 0, 1));
    tbl[22] = vv(0, 2'b00, 1, 0, 0, ex(1, 2'b01, 0, 0, 1));
    tbl[23] = vv(0, 2'b11, 0, 0, 0, ex(0, 2'b00, 0, 0, 1));
    tbl[24] = vv(0, 2'b11, 1, 1, 0, ex(1, 2'b10, 1, 0, 1));
    tbl[25] = vv(0, 2'b00, 0, 0, 0, ex(0, 2'b00, 1, 0, 1));

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].pg, tbl[i].ack, tbl[i].sof, tbl[i].e,
           $sformatf("tbl[%0d]", i), 1'b1);
    end

    // watchdog: OWN lasts exactly TO cycles, then one timeout pulse and re-arbitration
    step(0, 2'b00, 0, 0, 1, ex(0, 2'b00, 1, 0, 1), "to_sof", 1'b1);
    step(0, 2'b01, 0, 0, 0, ex(0, 2'b00, 1, 0, 1), "to_req", 1'b1);
    for (int i = 0; i < TO; i++) begin
      step(0, 2'b01, 1, 0, 0, ex(1, 2'b01, 0, 0, 1), $sformatf("to_own[%0d]", i), 1'b1);
    end
    step(0, 2'b01, 1, 0, 0, ex(0, 2'b00, 0, 1, 1), "to_pulse", 1'b1);
    step(0, 2'b01, 1, 0, 0, ex(1, 2'b01, 0, 0, 1), "to_rearb", 1'b1);
    step(0, 2'b00, 0, 0, 0, ex(1, 2'b00, 0, 0, 1), "to_drop", 1'b1);

    // presence window: host_present falls after PRES+1 SOF-less cycles
    step(0, 2'b00, 0, 0, 1, ex(0, 2'b00, 0, 0, 1), "pr_sof", 1'b1);
    for (int i = 0; i < PRES - 1; i++) begin
      step(0, 2'b00, 0, 0, 0, '0, "", 1'b0);
    end
    step(0, 2'b00, 0, 0, 0, ex(0, 2'b00, 0, 0, 1), "pr_hold0", 1'b1);
    step(0, 2'b00, 0, 0, 0, ex(0, 2'b00, 0, 0, 1), "pr_hold1", 1'b1);
    step(0, 2'b01, 0, 0, 0, ex(0, 2'b00, 0, 0, 0), "pr_drop", 1'b1);
    step(0, 2'b01, 0, 0, 0, ex(0, 2'b00, 0, 0, 0), "pr_nogrant", 1'b1);
    step(0, 2'b10, 0, 0, 1, ex(0, 2'b00, 0, 0, 0), "pr_sof2", 1'b1);
    step(0, 2'b10, 0, 0, 0, ex(0, 2'b00, 0, 0, 1), "pr_back", 1'b1);
    step(0, 2'b10, 1, 0, 0, ex(1, 2'b10, 1, 0, 1), "pr_own1", 1'b1);

    // reset while owning requester 1
    step(1, 2'b10, 1, 0, 0, ex(1, 2'b10, 1, 0, 1), "rst_req", 1'b1);
    step(0, 2'b10, 1, 0, 0, ex(0, 2'b00, 0, 0, 0), "rst_own", 1'b1);

`ifdef USB_IN_SCHED_BUDGET_EN
    step(0, 2'b00, 0, 0, 1, ex(0, 2'b00, 0, 0, 0), "bud_sof", 1'b1);
    step(0, 2'b01, 0, 0, 0, ex(0, 2'b00, 0, 0, 1), "bud_req", 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b01, 1, 1, 0, ex(1, 2'b01, 0, 0, 1), $sformatf("bud_ack[%0d]", i), 1'b1);
      step(0, 2'b01, 1, 0, 0, ex(0, 2'b00, 0, 0, 1), $sformatf("bud_idle[%0d]", i), 1'b1);
    end
    step(0, 2'b01, 1, 0, 0, ex(0, 2'b00, 0, 0, 1), "bud_block0", 1'b1);
    step(0, 2'b01, 1, 0, 0, ex(0, 2'b00, 0, 0, 1), "bud_block1", 1'b1);
    step(0, 2'b01, 1, 0, 1, ex(0, 2'b00, 0, 0, 1), "bud_sof_clr", 1'b1);
    step(0, 2'b01, 1, 0, 0, ex(0, 2'b00, 0, 0, 1), "bud_rearm", 1'b1);
    step(0, 2'b01, 1, 1, 1, ex(1, 2'b01, 0, 0, 1), "bud_ack_sof", 1'b1);
    step(0, 2'b01, 1, 0, 0, ex(0, 2'b00, 0, 0, 1), "bud_ack_sof_idle", 1'b1);
    // clear won, so four more packets fit before the limit
    for (int i = 0; i < 4; i++) begin
      step(0, 2'b01, 1, 1, 0, ex(1, 2'b01, 0, 0, 1), $sformatf("bud2_ack[%0d]", i), 1'b1);
      step(0, 2'b01, 1, 0, 0, ex(0, 2'b00, 0, 0, 1), $sformatf("bud2_idle[%0d]", i), 1'b1);
    end
    step(0, 2'b01, 1, 0, 0, ex(0, 2'b00, 0, 0, 1), "bud2_block", 1'b1);
`endif

    step(0, 2'b00, 0, 0, 0, '0, "", 1'b0);
    @(negedge clk_48mhz);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
